// File: rtl/ul_go_reg_if.sv
// UL register-bus and per-channel output handshake bundle for ul_go_reg.
// The slave modport is the register bank; the master modport is the bus driver and the output consumer.
interface ul_go_reg_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 2
);
  localparam int unsigned ADDR_TOTAL = 1 << ADDR_WIDTH;

  logic [ADDR_WIDTH+1:0]            s_ul_waddr;
  logic [DATA_WIDTH-1:0]            s_ul_wdata;
  logic                             s_ul_wvalid;
  logic                             s_ul_wready;
  logic [ADDR_WIDTH-1:0]            s_ul_raddr;
  logic                             s_ul_rvalid;
  logic                             s_ul_rready;
  logic [DATA_WIDTH-1:0]            m_ul_rdata;
  logic                             m_ul_rvalid;
  logic                             m_ul_rready;
  logic [ADDR_TOTAL*DATA_WIDTH-1:0] gp_out;
  logic [ADDR_TOTAL-1:0]            gp_out_valid;
  logic [ADDR_TOTAL-1:0]            gp_in_ready;

  modport slave (
    input  s_ul_waddr, s_ul_wdata, s_ul_wvalid, s_ul_raddr, s_ul_rvalid,
    input  m_ul_rready, gp_in_ready,
    output s_ul_wready, s_ul_rready, m_ul_rdata, m_ul_rvalid, gp_out, gp_out_valid
  );

  modport master (
    output s_ul_waddr, s_ul_wdata, s_ul_wvalid, s_ul_raddr, s_ul_rvalid,
    output m_ul_rready, gp_in_ready,
    input  s_ul_wready, s_ul_rready, m_ul_rdata, m_ul_rvalid, gp_out, gp_out_valid
  );
endinterface

// File: rtl/ul_go_reg.sv
// Bank of registered general-purpose outputs written over the UL bus with write/set/clear/toggle ops,
// each channel holding its update under a valid/ready handshake, plus a UL readback channel.
module ul_go_reg #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH  = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic        clk,
  input  logic        rst,
  ul_go_reg_if.slave  bus
);
  localparam int unsigned ADDR_TOTAL = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'b00,
    OP_SET    = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_TOGGLE = 2'b11
  } op_e;

  logic [ADDR_TOTAL-1:0][DATA_WIDTH-1:0] regs, regs_nxt;
  logic [ADDR_TOTAL-1:0]                 valid, valid_nxt;
  logic [DATA_WIDTH-1:0]                 rdata, rdata_nxt;
  logic                                  rvalid, rvalid_nxt;

  logic [ADDR_WIDTH-1:0] wr_ch;
  op_e                   wr_op;
  logic [DATA_WIDTH-1:0] wr_old;
  logic [DATA_WIDTH-1:0] wr_result;
  logic                  wr_ready;
  logic                  wr_fire;
  logic                  rd_ready;
  logic                  rd_fire;

  // Decode the write address into channel and operation.
  assign wr_ch  = bus.s_ul_waddr[ADDR_WIDTH-1:0];
  assign wr_op  = op_e'(bus.s_ul_waddr[ADDR_WIDTH+1:ADDR_WIDTH]);
  assign wr_old = regs[wr_ch];

  // A channel can take a new write once its pending update is gone or being taken this cycle.
  assign wr_ready = !valid[wr_ch] || bus.gp_in_ready[wr_ch];
  assign wr_fire  = bus.s_ul_wvalid && wr_ready;

  assign rd_ready = !rvalid || bus.m_ul_rready;
  assign rd_fire  = bus.s_ul_rvalid && rd_ready;

  // Read-modify-write result, always computed from the pre-edge register value.
  always_comb begin
    wr_result = wr_old;
    unique case (wr_op)
      OP_WRITE:  wr_result = bus.s_ul_wdata;
      OP_SET:    wr_result = wr_old | bus.s_ul_wdata;
      OP_CLEAR:  wr_result = wr_old & ~bus.s_ul_wdata;
      OP_TOGGLE: wr_result = wr_old ^ bus.s_ul_wdata;
      default:   wr_result = wr_old;
    endcase
  end

  // Next-state: consumes clear valid, an accepted write reloads and re-arms its channel.
  always_comb begin
    regs_nxt   = regs;
    valid_nxt  = valid & ~bus.gp_in_ready;
    rdata_nxt  = rdata;
    rvalid_nxt = rvalid && !bus.m_ul_rready;

    if (wr_fire) begin
      regs_nxt[wr_ch]  = wr_result;
      valid_nxt[wr_ch] = 1'b1;
    end

    if (rd_fire) begin
      rdata_nxt  = regs[bus.s_ul_raddr];
      rvalid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs   <= {ADDR_TOTAL{RESET_VALUE}};
      valid  <= '0;
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      regs   <= regs_nxt;
      valid  <= valid_nxt;
      rdata  <= rdata_nxt;
      rvalid <= rvalid_nxt;
    end
  end

  assign bus.s_ul_wready  = wr_ready;
  assign bus.s_ul_rready  = rd_ready;
  assign bus.m_ul_rdata   = rdata;
  assign bus.m_ul_rvalid  = rvalid;
  assign bus.gp_out       = regs;
  assign bus.gp_out_valid = valid;

endmodule

// File: tb/tb_ul_go_reg.sv
// Directed testbench for ul_go_reg: hand-computed expectations for writes, ops, handshakes,
// readback ordering and asynchronous reset.
module tb_ul_go_reg;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 2;
  localparam logic [DW-1:0] RV = 32'hA5;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  ul_go_reg_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifc ();

  ul_go_reg #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_VALUE(RV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] lane(input int i);
    return ifc.gp_out[i*DW +: DW];
  endfunction

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic [1:0] op, input logic [1:0] ch, input logic [DW-1:0] d);
    ifc.s_ul_waddr  = {op, ch};
    ifc.s_ul_wdata  = d;
    ifc.s_ul_wvalid = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    ifc.s_ul_waddr  = '0;
    ifc.s_ul_wdata  = '0;
    ifc.s_ul_wvalid = 1'b0;
    ifc.s_ul_raddr  = '0;
    ifc.s_ul_rvalid = 1'b0;
    ifc.m_ul_rready = 1'b0;
    ifc.gp_in_ready = '0;

    // 1: reset state
    repeat (3) cyc();
    for (int i = 0; i < 4; i++) check($sformatf("rst_lane%0d", i), 64'(lane(i)), 64'h0A5);
    check("rst_valid",  64'(ifc.gp_out_valid), 64'h0);
    check("rst_rvalid", 64'(ifc.m_ul_rvalid), 64'h0);
    check("rst_rdata",  64'(ifc.m_ul_rdata), 64'h0);
    rst = 1'b0;
    cyc();

    // 2: write ch1 with consumer stalled, then backpressure, then consume
    set_wr(2'b00, 2'd1, 32'h1234);
    #1 check("t2_wready_idle", 64'(ifc.s_ul_wready), 64'h1);
    cyc();
    ifc.s_ul_wvalid = 1'b0;
    check("t2_lane1", 64'(lane(1)), 64'h1234);
    check("t2_valid", 64'(ifc.gp_out_valid), 64'h2);
    set_wr(2'b00, 2'd1, 32'hBEEF);
    #1 check("t2_wready_busy", 64'(ifc.s_ul_wready), 64'h0);
    cyc();
    ifc.s_ul_wvalid = 1'b0;
    check("t2_lane1_held", 64'(lane(1)), 64'h1234);
    ifc.gp_in_ready = 4'b0010;
    cyc();
    check("t2_valid_consumed", 64'(ifc.gp_out_valid), 64'h0);
    check("t2_lane1_after", 64'(lane(1)), 64'h1234);

    // 3: set/clear/toggle on ch2, back-to-back with consumer ready
    ifc.gp_in_ready = 4'b1111;
    set_wr(2'b00, 2'd2, 32'hF0F0);
    cyc();
    check("t3_write", 64'(lane(2)), 64'hF0F0);
    set_wr(2'b01, 2'd2, 32'h000F);
    cyc();
    check("t3_set", 64'(lane(2)), 64'hF0FF);
    check("t3_set_valid", 64'(ifc.gp_out_valid), 64'h4);
    set_wr(2'b10, 2'd2, 32'hF000);
    cyc();
    check("t3_clear", 64'(lane(2)), 64'h00FF);
    check("t3_clear_valid", 64'(ifc.gp_out_valid), 64'h4);
    set_wr(2'b11, 2'd2, 32'h0101);
    cyc();
    check("t3_toggle", 64'(lane(2)), 64'h01FE);
    check("t3_toggle_valid", 64'(ifc.gp_out_valid), 64'h4);
    ifc.s_ul_wvalid = 1'b0;
    cyc();
    check("t3_drained", 64'(ifc.gp_out_valid), 64'h0);

    // 4: ch0 stalled does not block a write to ch3
    ifc.gp_in_ready = 4'b0000;
    set_wr(2'b00, 2'd0, 32'hAAAA);
    cyc();
    check("t4_valid0", 64'(ifc.gp_out_valid), 64'h1);
    set_wr(2'b00, 2'd3, 32'h3333);
    #1 check("t4_wready_ch3", 64'(ifc.s_ul_wready), 64'h1);
    cyc();
    ifc.s_ul_wvalid = 1'b0;
    check("t4_lane3", 64'(lane(3)), 64'h3333);
    check("t4_lane0", 64'(lane(0)), 64'hAAAA);
    check("t4_valid", 64'(ifc.gp_out_valid), 64'h9);
    ifc.gp_in_ready = 4'b1001;
    cyc();
    check("t4_drained", 64'(ifc.gp_out_valid), 64'h0);

    // 5: same-cycle write and read of ch1 returns the old value
    ifc.gp_in_ready = 4'b1111;
    set_wr(2'b00, 2'd1, 32'h9);
    cyc();
    ifc.m_ul_rready = 1'b1;
    set_wr(2'b00, 2'd1, 32'h5);
    ifc.s_ul_raddr  = 2'd1;
    ifc.s_ul_rvalid = 1'b1;
    #1 check("t5_rready", 64'(ifc.s_ul_rready), 64'h1);
    cyc();
    ifc.s_ul_wvalid = 1'b0;
    check("t5_rvalid", 64'(ifc.m_ul_rvalid), 64'h1);
    check("t5_rdata_old", 64'(ifc.m_ul_rdata), 64'h9);
    check("t5_lane1_new", 64'(lane(1)), 64'h5);
    cyc();
    check("t5_rdata_new", 64'(ifc.m_ul_rdata), 64'h5);
    ifc.m_ul_rready = 1'b0;
    ifc.s_ul_raddr  = 2'd0;
    #1 check("t5_rready_stall", 64'(ifc.s_ul_rready), 64'h0);
    cyc();
    check("t5_rdata_hold", 64'(ifc.m_ul_rdata), 64'h5);
    check("t5_rvalid_hold", 64'(ifc.m_ul_rvalid), 64'h1);

    // 6: asynchronous reset with pending update and pending read data
    ifc.gp_in_ready = 4'b0000;
    set_wr(2'b00, 2'd1, 32'h77);
    cyc();
    ifc.s_ul_wvalid = 1'b0;
    check("t6_pre_valid", 64'(ifc.gp_out_valid), 64'h2);
    check("t6_pre_lane1", 64'(lane(1)), 64'h77);
    #1 rst = 1'b1;
    #1;
    check("t6_valid", 64'(ifc.gp_out_valid), 64'h0);
    check("t6_rvalid", 64'(ifc.m_ul_rvalid), 64'h0);
    check("t6_lane1", 64'(lane(1)), 64'h0A5);
    check("t6_lane0", 64'(lane(0)), 64'h0A5);
    ifc.s_ul_rvalid = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    cyc();
    check("t6_post_valid", 64'(ifc.gp_out_valid), 64'h0);
    check("t6_post_rvalid", 64'(ifc.m_ul_rvalid), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
